// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared GPIO definitions: event-FSM encoding, key-code width and the
// one-hot / lowest-index helper used by the keypad, switch and button blocks.
package keypad_matrix_scanner_pkg;

  localparam int KEY_CODE_W = 4;
  localparam int MAX_KEYS   = 16;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_MULTI    = 2'd2
  } keyState_t;

  typedef struct packed {
    logic                  isZero;
    logic                  isOne;
    logic [KEY_CODE_W-1:0] index;
  } keyPop_t;

  // Classifies a key vector as none / exactly one / several; index is the lowest set bit.
  function automatic keyPop_t keyPop(input logic [MAX_KEYS-1:0] bits);
    keyPop_t     res;
    int unsigned cnt;
    res = '0;
    cnt = 0;
    for (int i = MAX_KEYS - 1; i >= 0; i--) begin
      if (bits[i]) begin
        cnt++;
        res.index = KEY_CODE_W'(i);
      end
    end
    res.isZero = (cnt == 0);
    res.isOne  = (cnt == 1);
    return res;
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_sync2.sv
// Two-flop synchronizer for asynchronous GPIO input lines, shared by the
// keypad, switch and button blocks.
module gpio_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic [WIDTH-1:0] i_Async,
  output logic [WIDTH-1:0] o_Sync
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      meta   <= '0;
      o_Sync <= '0;
    end else begin
      meta   <= i_Async;
      o_Sync <= meta;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Column-strobed keypad scanner: snapshots the whole matrix each scan, debounces
// snapshots and reports single-key press events through a valid/ack handshake.
module keypad_matrix_scanner
  import keypad_matrix_scanner_pkg::*;
#(
  parameter int COLS           = 4,
  parameter int ROWS           = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  output logic [COLS-1:0]       o_Col_En,
  input  logic [ROWS-1:0]       i_Row,
  output logic                  o_Key_Valid,
  output logic [KEY_CODE_W-1:0] o_Key_Code,
  input  logic                  i_Key_Ack,
  output logic                  o_Key_Held,
  output logic                  o_Multi,
  output logic                  o_Overrun,
  output logic [1:0]            o_Dbg_State
);

  localparam int KEYS  = ROWS * COLS;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W = 4;

  logic [ROWS-1:0]       rowSync;
  logic [PRE_W-1:0]      prescaler;
  logic [COL_W-1:0]      colIdx;
  logic [COL_W-1:0]      colNext;
  logic [KEYS-1:0]       snapshot;
  logic [KEYS-1:0]       snapNext;
  logic [KEYS-1:0]       prevSnap;
  logic [KEYS-1:0]       debounced;
  logic [CNT_W-1:0]      stableCnt;
  logic                  scanTick;
  logic                  scanDone;
  keyState_t             state;
  keyState_t             stateNext;
  keyPop_t               debPop;
  logic                  pressEvent;
  logic                  ackTaken;
  logic                  validNext;
  logic                  overrunNext;
  logic [KEY_CODE_W-1:0] codeNext;

  gpio_sync2 #(.WIDTH(ROWS)) u_rowSync (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Async (i_Row),
    .o_Sync  (rowSync)
  );

  assign scanTick = (prescaler == PRE_W'(SCAN_DIV - 1));
  assign scanDone = scanTick && (colIdx == COL_W'(COLS - 1));
  assign colNext  = (colIdx == COL_W'(COLS - 1)) ? '0 : colIdx + 1'b1;

  // Rows are sampled at the end of the dwell; bit index is row*COLS + col.
  always_comb begin
    snapNext = snapshot;
    if (scanTick) begin
      for (int k = 0; k < KEYS; k++) begin
        if ((k % COLS) == int'(colIdx)) snapNext[k] = rowSync[k / COLS];
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      prescaler <= '0;
      colIdx    <= '0;
      o_Col_En  <= COLS'(1);
      snapshot  <= '0;
      prevSnap  <= '0;
      stableCnt <= '0;
      debounced <= '0;
    end else begin
      snapshot <= snapNext;
      if (scanTick) begin
        prescaler <= '0;
        colIdx    <= colNext;
        o_Col_En  <= COLS'(1) << colNext;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      if (scanDone) begin
        prevSnap <= snapNext;
        if (snapNext == prevSnap) begin
          if (stableCnt != CNT_W'(DEBOUNCE_SCANS)) stableCnt <= stableCnt + 1'b1;
          if (stableCnt == CNT_W'(DEBOUNCE_SCANS - 1)) debounced <= snapNext;
        end else begin
          stableCnt <= '0;
        end
      end
    end
  end

  assign debPop = keyPop(MAX_KEYS'(debounced));

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= ST_RELEASED;
    else          state <= stateNext;
  end

  // Only a release-to-single-key transition produces a press event.
  always_comb begin
    stateNext  = state;
    pressEvent = 1'b0;
    case (state)
      ST_RELEASED: begin
        if (debPop.isOne) begin
          stateNext  = ST_PRESSED;
          pressEvent = 1'b1;
        end else if (!debPop.isZero) begin
          stateNext = ST_MULTI;
        end
      end
      ST_PRESSED: begin
        if (debPop.isZero)     stateNext = ST_RELEASED;
        else if (!debPop.isOne) stateNext = ST_MULTI;
      end
      ST_MULTI: begin
        if (debPop.isZero) stateNext = ST_RELEASED;
      end
      default: stateNext = ST_RELEASED;
    endcase
  end

  // Handshake: an event is offered by o_Key_Valid with o_Key_Code held stable;
  // it is consumed on any edge where valid and i_Key_Ack are both high, and ack
  // with valid low has no effect. An event that finds the slot still occupied
  // (and not being acked) is dropped and flagged on o_Overrun until the next ack.
  always_comb begin
    validNext   = o_Key_Valid;
    codeNext    = o_Key_Code;
    overrunNext = o_Overrun;
    ackTaken    = o_Key_Valid && i_Key_Ack;
    if (ackTaken) begin
      validNext   = 1'b0;
      overrunNext = 1'b0;
    end
    if (pressEvent) begin
      if (!o_Key_Valid || ackTaken) begin
        validNext = 1'b1;
        codeNext  = debPop.index;
      end else begin
        overrunNext = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Key_Valid <= 1'b0;
      o_Key_Code  <= '0;
      o_Overrun   <= 1'b0;
    end else begin
      o_Key_Valid <= validNext;
      o_Key_Code  <= codeNext;
      o_Overrun   <= overrunNext;
    end
  end

  assign o_Key_Held  = (state == ST_PRESSED);
  assign o_Multi     = (state == ST_MULTI);
  assign o_Dbg_State = state;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: modelled switch matrix, directed scenarios and
// random key patterns checked against a pattern-level event/handshake model.
`timescale 1ns/1ps
module tb_keypad_matrix_scanner;

  localparam int COLS   = 4;
  localparam int ROWS   = 4;
  localparam int SDIV   = 4;
  localparam int DEB    = 2;
  localparam int SCAN   = COLS * SDIV;
  localparam int SETTLE = 7 * SCAN;

  localparam int M_IDLE = 0;
  localparam int M_ONE  = 1;
  localparam int M_MANY = 2;

  logic            i_Clk = 1'b0;
  logic            i_Rst_n = 1'b0;
  logic [COLS-1:0] o_Col_En;
  logic [ROWS-1:0] i_Row;
  logic            o_Key_Valid;
  logic [3:0]      o_Key_Code;
  logic            i_Key_Ack = 1'b0;
  logic            o_Key_Held;
  logic            o_Multi;
  logic            o_Overrun;
  logic [1:0]      dbgState;

  logic [15:0]     keyDown = '0;

  keypad_matrix_scanner #(
    .COLS(COLS), .ROWS(ROWS), .SCAN_DIV(SDIV), .DEBOUNCE_SCANS(DEB)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst_n     (i_Rst_n),
    .o_Col_En    (o_Col_En),
    .i_Row       (i_Row),
    .o_Key_Valid (o_Key_Valid),
    .o_Key_Code  (o_Key_Code),
    .i_Key_Ack   (i_Key_Ack),
    .o_Key_Held  (o_Key_Held),
    .o_Multi     (o_Multi),
    .o_Overrun   (o_Overrun),
    .o_Dbg_State (dbgState)
  );

  // Clock / reset.
  always #5 i_Clk = ~i_Clk;

  // Ideal switch matrix: a row reads high when a pressed key sits in the strobed column.
  always_comb begin
    i_Row = '0;
    for (int r = 0; r < ROWS; r++) i_Row[r] = |(keyDown[r*COLS +: COLS] & o_Col_En);
  end

  // Scoreboard.
  int         vecCnt = 0;
  int         errCnt = 0;
  logic [3:0] expQ[$];
  logic [3:0] obsQ[$];
  logic       prevValid = 1'b0;

  always @(negedge i_Clk) begin
    if (o_Key_Valid && !prevValid) obsQ.push_back(o_Key_Code);
    prevValid = o_Key_Valid;
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: keypad state and event slot, at key-pattern granularity.
  int         mState = M_IDLE;
  bit         mValid = 1'b0;
  bit         mOverrun = 1'b0;
  logic [3:0] mCode = '0;

  function automatic int lowestIdx(input logic [15:0] pat);
    for (int i = 0; i < 16; i++) if (pat[i]) return i;
    return 0;
  endfunction

  task automatic raiseEvent(input int idx);
    if (mValid) begin
      mOverrun = 1'b1;
    end else begin
      mValid = 1'b1;
      mCode  = 4'(idx);
      expQ.push_back(4'(idx));
    end
  endtask

  task automatic setKeys(input logic [15:0] pat);
    int n;
    keyDown = pat;
    n = $countones(pat);
    case (mState)
      M_IDLE: begin
        if (n == 1) begin
          mState = M_ONE;
          raiseEvent(lowestIdx(pat));
        end else if (n > 1) begin
          mState = M_MANY;
        end
      end
      M_ONE:   if (n == 0) mState = M_IDLE; else if (n > 1) mState = M_MANY;
      default: if (n == 0) mState = M_IDLE;
    endcase
  endtask

  task automatic drainCheck(input string tag);
    int n;
    checkEq({tag, "_evcount"}, 32'(obsQ.size()), 32'(expQ.size()));
    n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < n; i++) checkEq({tag, "_evcode"}, 32'(obsQ[i]), 32'(expQ[i]));
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic checkState(input string tag);
    checkEq({tag, "_valid"}, 32'(o_Key_Valid), 32'(mValid));
    if (mValid) checkEq({tag, "_code"}, 32'(o_Key_Code), 32'(mCode));
    checkEq({tag, "_held"}, 32'(o_Key_Held), 32'(mState == M_ONE));
    checkEq({tag, "_multi"}, 32'(o_Multi), 32'(mState == M_MANY));
    checkEq({tag, "_overrun"}, 32'(o_Overrun), 32'(mOverrun));
    drainCheck(tag);
  endtask

  // Driver tasks.
  task automatic settle(input string tag);
    repeat (SETTLE) @(negedge i_Clk);
    checkState(tag);
  endtask

  task automatic ackPulse(input string tag);
    i_Key_Ack = 1'b1;
    @(negedge i_Clk);
    i_Key_Ack = 1'b0;
    if (mValid) begin
      mValid   = 1'b0;
      mOverrun = 1'b0;
    end
    checkEq({tag, "_ack_valid"}, 32'(o_Key_Valid), 32'(mValid));
    checkEq({tag, "_ack_overrun"}, 32'(o_Overrun), 32'(mOverrun));
  endtask

  task automatic alignScan(input string tag);
    logic [COLS-1:0] last;
    int n;
    last = o_Col_En;
    n = 0;
    do begin
      last = o_Col_En;
      @(negedge i_Clk);
      n++;
    end while (!(o_Col_En == 4'b0001 && last == 4'b1000) && n < 4 * SCAN);
    checkEq({tag, "_align"}, 32'(n < 4 * SCAN), 32'd1);
  endtask

  task automatic waitValid(input string tag, input int maxN, output int n);
    n = 0;
    while (!o_Key_Valid && n < maxN) begin
      @(negedge i_Clk);
      n++;
    end
    checkEq({tag, "_timeout"}, 32'(o_Key_Valid), 32'd1);
  endtask

  initial begin
    int lat;
    int kind;
    int a;
    int b;

    // Reset check.
    repeat (3) @(negedge i_Clk);
    checkEq("rst_colen", 32'(o_Col_En), 32'h1);
    checkEq("rst_outs", 32'({o_Key_Valid, o_Key_Code, o_Key_Held, o_Multi, o_Overrun}), 32'd0);
    i_Rst_n = 1'b1;
    for (int k = 0; k < 5 * COLS; k++) begin
      checkEq("scan_colen", 32'(o_Col_En), 32'(1 << ((k / SDIV) % COLS)));
      checkEq("scan_outs", 32'({o_Key_Valid, o_Key_Held, o_Multi, o_Overrun}), 32'd0);
      @(negedge i_Clk);
    end

    // Single press of key 9 (row 2, column 1), scan-aligned for the latency window.
    alignScan("press");
    setKeys(16'(1 << 9));
    waitValid("press", 90, lat);
    checkEq("press_latency", 32'(lat >= 48 && lat <= 65), 32'd1);
    checkEq("press_code", 32'(o_Key_Code), 32'd9);
    @(negedge i_Clk);
    checkEq("press_held", 32'(o_Key_Held), 32'd1);
    ackPulse("press");
    setKeys('0);
    repeat (30) @(negedge i_Clk);
    checkEq("release_early_held", 32'(o_Key_Held), 32'd1);
    repeat (40) @(negedge i_Clk);
    checkEq("release_held", 32'(o_Key_Held), 32'd0);
    settle("release");

    // Bounce: toggle key 9 every 10 clk for 100 clk, then hold.
    alignScan("bounce");
    for (int t = 0; t < 10; t++) begin
      keyDown = (t % 2 == 0) ? 16'(1 << 9) : 16'h0;
      repeat (10) @(negedge i_Clk);
    end
    checkEq("bounce_quiet", 32'(obsQ.size()), 32'd0);
    setKeys(16'(1 << 9));
    settle("bounce_hold");
    ackPulse("bounce");
    setKeys('0);
    settle("bounce_rel");

    // Multi: keys 0 and 5, drop to key 0, release all, press key 0.
    setKeys(16'h0021);
    settle("multi_two");
    setKeys(16'h0001);
    settle("multi_one");
    setKeys('0);
    settle("multi_none");
    setKeys(16'h0001);
    settle("multi_fresh");
    ackPulse("multi");
    setKeys('0);
    settle("multi_rel");

    // Overrun: key 3 pending without ack, then key 12.
    setKeys(16'(1 << 3));
    settle("ovr_first");
    setKeys('0);
    settle("ovr_rel");
    setKeys(16'(1 << 12));
    settle("ovr_second");
    ackPulse("ovr");
    setKeys('0);
    settle("ovr_done");

    // Reset with an event pending and the key still held.
    setKeys(16'(1 << 6));
    settle("rmid_pre");
    #1 i_Rst_n = 1'b0;
    #1;
    checkEq("rmid_colen", 32'(o_Col_En), 32'h1);
    checkEq("rmid_outs", 32'({o_Key_Valid, o_Key_Code, o_Key_Held, o_Multi, o_Overrun}), 32'd0);
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    mState = M_IDLE;
    mValid = 1'b0;
    mOverrun = 1'b0;
    expQ.delete();
    obsQ.delete();
    setKeys(16'(1 << 6));
    waitValid("rmid", 90, lat);
    settle("rmid_post");
    ackPulse("rmid");
    setKeys('0);
    settle("rmid_rel");

    // Random key patterns with random acknowledgement.
    for (int r = 0; r < 20; r++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        setKeys('0);
      end else if (kind == 3) begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        setKeys(16'((1 << a) | (1 << b)));
      end else begin
        setKeys(16'(1 << $urandom_range(0, 15)));
      end
      settle("rand");
      if ($urandom_range(0, 1) == 1) ackPulse("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Input-side counterpart of the multiplexed seven-segment display driver in the GPIO peripheral group.
- Drives one-hot column strobes into an ROWS x COLS switch matrix and samples the row lines.
- Debounces whole-matrix snapshots and reports single-key press events to the bus-facing GPIO register block through a valid/ack handshake.

Parameters:
- COLS, 4, number of column strobes; 2..8.
- ROWS, 4, number of row inputs; 2..8. ROWS*COLS must be ≤ 16.
- SCAN_DIV, 1000, clocks of dwell per column; must be ≥ 4.
- DEBOUNCE_SCANS, 4, consecutive identical full-matrix snapshots required before the debounced state updates; 1..15.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_n  in  1  reset, asynchronous assert, active-low.
- o_Col_En  out  COLS  one-hot active-high column strobe.
- i_Row  in  ROWS  raw row lines, active-high (1 = pressed), asynchronous to i_Clk.
- o_Key_Valid  out  1  press event pending.
- o_Key_Code  out  4  key index = row*COLS + col; stable while o_Key_Valid = 1.
- i_Key_Ack  in  1  consumer accepts the pending event.
- o_Key_Held  out  1  exactly one key debounced-pressed and it was reported.
- o_Multi  out  1  debounced state has two or more keys pressed.
- o_Overrun  out  1  sticky: a press event was dropped while one was pending.

Behaviour:
- Reset (async, i_Rst_n = 0):
  - o_Col_En = 1 (column 0); all other outputs = 0.
  - Prescaler, column index, snapshot, previous snapshot, stable counter and debounced state all = 0.
  - FSM in RELEASED. A reset mid-scan or with an event pending discards everything; no event is reported after reset.
- Sync: i_Row passes through a 2-flop synchronizer before any use.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1.
  - On terminal count: the synchronized rows are written into the snapshot bits of the current column, the column index advances (wraps COLS-1 -> 0), and o_Col_En updates in the same edge.
  - Sampling at the end of the dwell covers synchronizer latency plus line settling.
- Snapshot complete: occurs at the terminal count of column COLS-1.
  - If snapshot == previous snapshot, the stable counter increments, saturating at DEBOUNCE_SCANS. Otherwise it clears to 0.
  - Previous snapshot <= snapshot.
  - On the edge where the counter reaches DEBOUNCE_SCANS, the debounced state <= snapshot.
- Event FSM, evaluated in the cycle after the debounced state updates:
  - RELEASED: debounced has exactly one bit set -> PRESSED and raise a press event with code = bit index. Two or more bits set -> MULTI. Zero bits -> stay.
  - PRESSED: zero bits -> RELEASED. Two or more bits -> MULTI. A different single key without passing through zero raises no event.
  - MULTI: zero bits -> RELEASED only. A drop back to a single key raises no event.
  - o_Key_Held = (state == PRESSED). o_Multi = (state == MULTI).
- Handshake:
  - A press event sets o_Key_Valid = 1 and loads o_Key_Code.
  - Valid stays high until a cycle where i_Key_Ack = 1; it clears on the next edge.
  - Ack while valid = 0 is ignored.
  - A press event arriving while valid = 1 and no ack in that cycle: the event is dropped, code is unchanged, and o_Overrun is set.
  - Event and ack in the same cycle: the ack clears the old event and the new event loads, so valid stays 1 with the new code.
  - o_Overrun clears only on an accepted ack.
- Latency: from a stable press to o_Key_Valid is between DEBOUNCE_SCANS+1 and DEBOUNCE_SCANS+2 full scans, plus 1 clock.

Decomposition:
- Shared GPIO package holds:
  - the FSM state encoding (RELEASED, PRESSED, MULTI);
  - the key-code width constant (4);
  - a popcount-is-one / priority-index function reused by the switch and button blocks.
- One natural sub-module: gpio_sync2, the 2-flop synchronizer parameterized by width. It is shared with the other GPIO input blocks.

Test Plan:
Bench parameters: COLS=4, ROWS=4, SCAN_DIV=4, DEBOUNCE_SCANS=2, so 1 scan = 16 clk.
- Reset check: hold i_Rst_n low, then release. o_Col_En sequence is 0001, 0010, 0100, 1000, 0001, each held 4 clk. All other outputs stay 0.
- Single press: hold the row-2 line high only while column 1 is strobed (modelled switch). o_Key_Valid rises within 48..65 clk with o_Key_Code = 9 and o_Key_Held = 1. Pulse i_Key_Ack 1 clk: valid drops the next clk. Release: o_Key_Held = 0 after 3-4 scans, with no second event.
- Bounce: toggle the key every 10 clk for 100 clk, then hold. Exactly one event with code 9 occurs, and none during the toggling.
- Multi: press keys 0 and 5 together. o_Multi = 1 and no valid. Release key 5 only: still no event. Release all, then press key 0: event with code 0.
- Overrun: press key 3, do not ack, release, then press key 12. Code stays 3 and o_Overrun = 1. Ack: valid = 0 and o_Overrun = 0.
- Reset mid-event: with valid = 1, assert i_Rst_n low for 1 clk. All outputs return to reset values immediately. With the key still held, a fresh event follows after the debounce latency.
